// File: rtl/gray_cdc_pkg.sv
// Shared definitions for the gray-pointer CDC path: tracker state encoding
// and gray/binary conversions also used by the upstream synchroniser.
package gray_cdc_pkg;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_TRACK = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   localparam int MAX_W = 32;

   function automatic logic [MAX_W-1:0] bin_to_gray(input logic [MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Zero-extended inputs decode correctly once truncated back to the caller's width.
   function automatic logic [MAX_W-1:0] gray_to_bin(input logic [MAX_W-1:0] g);
      logic [MAX_W-1:0] b;
      b = '0;
      b[MAX_W-1] = g[MAX_W-1];
      for (int i = MAX_W-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational W-bit gray-to-binary decoder: each binary bit is the XOR of
// all gray bits from the MSB down to that position.
module gray_to_bin #(
   parameter int W = 4
) (
   input  logic [W-1:0] i_gray,
   output logic [W-1:0] o_bin
);

   assign o_bin[W-1] = i_gray[W-1];

   genvar gi;
   generate
      for (gi = W-2; gi >= 0; gi--) begin : g_chain
         assign o_bin[gi] = o_bin[gi+1] ^ i_gray[gi];
      end
   endgenerate

endmodule

// File: rtl/gray_ptr_tracker.sv
// Fast-domain tracker for a synchronised gray pointer: classifies each sample
// as hold / +1 / -1 / illegal and keeps a signed position plus sticky error.
module gray_ptr_tracker
   import gray_cdc_pkg::*;
#(
   parameter int W     = 4,
   parameter int CNT_W = 16,
   parameter int ERR_W = 8
) (
   input  logic             i_clk_f,
   input  logic             i_rst_n,
   input  logic [W-1:0]     i_gray,
   input  logic             i_clr,
   output logic [W-1:0]     o_bin,
   output logic             o_chg,
   output logic             o_dir,
   output logic [CNT_W-1:0] o_pos,
   output logic             o_err,
   output logic [ERR_W-1:0] o_err_cnt,
   output logic [1:0]       o_state
);

   logic [W-1:0]     w_bin;
   logic [W-1:0]     w_delta;
   logic             w_step_up;
   logic             w_step_dn;
   logic             w_illegal;

   state_t           r_state;
   logic [W-1:0]     r_base;
   logic [W-1:0]     r_bin;
   logic             r_chg;
   logic             r_dir;
   logic [CNT_W-1:0] r_pos;
   logic             r_err;
   logic [ERR_W-1:0] r_err_cnt;

   gray_to_bin #(.W(W)) u_g2b (
      .i_gray (i_gray),
      .o_bin  (w_bin)
   );

   // Modulo-2^W difference makes pointer wrap a legal single step both ways.
   assign w_delta   = w_bin - r_base;
   assign w_step_up = (w_delta == {{(W-1){1'b0}}, 1'b1});
   assign w_step_dn = (w_delta == {W{1'b1}});
   assign w_illegal = (w_delta != '0) && !w_step_up && !w_step_dn;

   always_ff @(posedge i_clk_f) begin
      if (!i_rst_n) begin
         r_state   <= ST_INIT;
         r_base    <= '0;
         r_bin     <= '0;
         r_chg     <= 1'b0;
         r_dir     <= 1'b0;
         r_pos     <= '0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else if (i_clr) begin
         // Clear wins over any step seen this cycle; the next edge re-baselines.
         r_state   <= ST_INIT;
         r_base    <= w_bin;
         r_bin     <= w_bin;
         r_chg     <= 1'b0;
         r_dir     <= 1'b0;
         r_pos     <= '0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_base <= w_bin;
         r_bin  <= w_bin;
         r_chg  <= 1'b0;
         case (r_state)
            ST_INIT: begin
               r_state <= ST_TRACK;
            end
            ST_TRACK: begin
               if (w_step_up) begin
                  r_chg <= 1'b1;
                  r_dir <= 1'b1;
                  r_pos <= r_pos + 1'b1;
               end else if (w_step_dn) begin
                  r_chg <= 1'b1;
                  r_dir <= 1'b0;
                  r_pos <= r_pos - 1'b1;
               end else if (w_illegal) begin
                  r_err   <= 1'b1;
                  r_state <= ST_FAULT;
                  if (r_err_cnt != {ERR_W{1'b1}}) r_err_cnt <= r_err_cnt + 1'b1;
               end
            end
            ST_FAULT: begin
               if (w_illegal && (r_err_cnt != {ERR_W{1'b1}})) begin
                  r_err_cnt <= r_err_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= ST_INIT;
            end
         endcase
      end
   end

   assign o_bin     = r_bin;
   assign o_chg     = r_chg;
   assign o_dir     = r_dir;
   assign o_pos     = r_pos;
   assign o_err     = r_err;
   assign o_err_cnt = r_err_cnt;
   assign o_state   = r_state;

endmodule

// File: doc/gray_ptr_tracker.md
# gray_ptr_tracker

Fast-domain consumer of a gray-coded pointer that has already been double-flop synchronised from a slow clock domain. Decodes each sample to binary, classifies the change against the previous sample as hold, +1, −1 or illegal, and maintains a wide signed position. Illegal multi-step jumps latch a sticky fault that freezes the position until software clears it. Sits directly after the gray-code synchroniser, feeding pointer-compare and occupancy logic.

## Interface
- W, 4: pointer width in bits; must match the synchroniser width.
- CNT_W, 16: width of the extended signed position o_pos.
- ERR_W, 8: width of the saturating illegal-step counter.

- i_clk_f  in  1  fast clock; sole clock of the block.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_gray  in  W  synchronised gray-coded pointer.
- i_clr  in  1  synchronous clear; returns to INIT and zeroes position and error state.
- o_bin  out  W  binary decode of the last sampled i_gray.
- o_chg  out  1  one-cycle pulse for a legal ±1 step.
- o_dir  out  1  direction of the last legal step: 1 = up, 0 = down.
- o_pos  out  CNT_W  signed accumulated position.
- o_err  out  1  sticky flag for an illegal step.
- o_err_cnt  out  ERR_W  saturating count of illegal steps.

## Operation
- Each edge: bin_in = gray_to_bin(i_gray), where bit i is the XOR of gray bits W-1 down to i.
- Compute delta = bin_in − r_base, modulo 2^W.
- Register r_base holds the previous bin_in; it is updated every edge in every state.
- States and transitions:
  - INIT: capture the baseline; o_bin = bin_in; o_chg = 0; o_pos unchanged (0). Next state TRACK.
  - TRACK, delta = 0: hold; o_chg = 0.
  - TRACK, delta = 1: o_chg = 1, o_dir = 1, o_pos + 1.
  - TRACK, delta = 2^W−1: o_chg = 1, o_dir = 0, o_pos − 1.
  - TRACK, any other delta: illegal. Set o_err = 1, increment o_err_cnt, o_chg = 0, o_pos unchanged. Next state FAULT.
  - FAULT: o_bin keeps decoding; o_chg held 0; o_pos frozen. Each illegal delta still increments o_err_cnt. Exit only via i_clr or reset.
- o_pos arithmetic: two's complement, wraps modulo 2^CNT_W with no saturation.
- o_err_cnt: saturates at 2^ERR_W−1.
- Pointer wrap: 2^W−1 → 0 is a legal +1 step; 0 → 2^W−1 is a legal −1 step.

## Timing
- Every output is registered.
- Latency: i_gray sampled at edge n appears in all outputs after edge n.
- Reset value of every output is 0, state is INIT, r_base = 0.
- i_clr has priority over any step evaluated in the same cycle. It forces state INIT with o_pos, o_err, o_err_cnt, o_chg and o_dir = 0. The next edge captures a fresh baseline.
- Reset or i_clr asserted mid-step discards that step; nothing is counted.
- The first edge after reset or clear never pulses o_chg, whatever the i_gray value.
- Source contract: i_gray changes at most once per i_clk_f cycle, by one gray step. Any violation is reported as illegal.

## Structure
- Package gray_cdc_pkg holds:
  - the state encoding (INIT, TRACK, FAULT);
  - constant functions bin_to_gray and gray_to_bin, shared with the upstream synchroniser.
- One natural sub-module: gray_to_bin, a parameterised W-bit XOR prefix chain (combinational). Instanced once here; reusable elsewhere.
- The rest is a single always block for the FSM and counters.

## Test plan
All cases use W=4, CNT_W=8, ERR_W=8.
- Reset, then hold i_gray=0110 → after 1 edge: o_bin=4, o_chg=0, o_pos=0, state TRACK; output stays stable while held.
- Gray sequence 0110, 0111, 0101 (4, 5, 6) → o_chg pulses on two edges, o_dir=1, o_pos=1 then 2.
- Wrap: from gray 1000 (15) to 0000 (0) → o_chg=1, o_dir=1, o_pos+1, o_err=0. Reverse 0000→1000 → o_dir=0, o_pos−1.
- Illegal step, TRACK at 0 then i_gray=0011 (2) → o_err=1, o_err_cnt=1, o_chg=0, o_pos unchanged. A following legal step gives no o_chg and no o_pos change. Another illegal jump gives o_err_cnt=2.
- Position wrap: 127 consecutive up steps, then one more → o_pos goes 127 → −128. o_err_cnt saturation: 300 illegal steps → 255.
- i_clr asserted in the same cycle as a +1 step while in FAULT → that step is ignored; o_pos=0, o_err=0, o_err_cnt=0. The next edge re-baselines with o_chg=0.
